// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, drives the icache lookup address, holds one fetched
// instruction for decode, and sequences execute redirects and fence.i invalidation.
module ifu_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic                  clock,
    input  logic                  rst_n_sync,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [DATA_WIDTH-1:0] cache_data,
    input  logic                  cache_hit,
    output logic                  cache_fence_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  fence_i_req
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  valid_q;
    logic                  valid_next;
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic [ADDR_WIDTH-1:0] hold_pc_next;
    logic [DATA_WIDTH-1:0] hold_inst;
    logic [DATA_WIDTH-1:0] hold_inst_next;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  unused_redirect_low;

    // Instructions are word aligned, so the low target bits are dropped.
    assign redirect_target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];

    assign cache_addr    = pc;
    assign cache_fence_i = (state == ST_FLUSH);
    assign out_valid     = valid_q;
    assign out_pc        = hold_pc;
    assign out_inst      = hold_inst;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        valid_next     = valid_q;
        hold_pc_next   = hold_pc;
        hold_inst_next = hold_inst;
        capture        = 1'b0;

        if (redirect_valid) begin
            // A held instruction is dropped; a handshake this cycle still counts on decode's side.
            pc_next    = redirect_target;
            valid_next = 1'b0;
            state_next = fence_i_req ? ST_FLUSH : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    capture = cache_hit;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        if (cache_hit) begin
                            capture = 1'b1;
                        end else begin
                            valid_next = 1'b0;
                            state_next = ST_FETCH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_next = ST_FETCH;
                end
                default: begin
                    valid_next = 1'b0;
                    state_next = ST_FETCH;
                end
            endcase
        end

        if (capture) begin
            hold_inst_next = cache_data;
            hold_pc_next   = pc;
            pc_next        = pc + PC_STEP;
            valid_next     = 1'b1;
            state_next     = ST_VALID;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n_sync) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            valid_q   <= 1'b0;
            hold_pc   <= RESET_PC;
            hold_inst <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            valid_q   <= valid_next;
            hold_pc   <= hold_pc_next;
            hold_inst <= hold_inst_next;
        end
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Instruction-fetch control stage that sits directly upstream of the icache. It owns the PC and presents it to the icache as the lookup address. On a hit it captures the instruction into a one-entry output register. It hands instructions to the decode stage over a valid/ready handshake, applies redirects from execute, and sequences fence.i invalidation of the icache.

Parameters:
ADDR_WIDTH, 32, PC/address width
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h3000_0000, PC loaded on reset

Ports:
clock  input  1  system clock
rst_n_sync  input  1  synchronous active-low reset
cache_addr  output  ADDR_WIDTH  lookup address to icache
cache_data  input  DATA_WIDTH  icache read data; valid only when cache_hit=1
cache_hit  input  1  icache hit for current cache_addr (combinational from icache)
cache_fence_i  output  1  invalidate-all pulse to icache
out_valid  output  1  instruction valid toward decode
out_ready  input  1  decode accepts instruction
out_pc  output  ADDR_WIDTH  PC of out_inst
out_inst  output  DATA_WIDTH  fetched instruction
redirect_valid  input  1  execute redirect request (single-cycle pulse)
redirect_pc  input  ADDR_WIDTH  redirect target
fence_i_req  input  1  qualifies redirect_valid as a fence.i redirect

Behaviour:
- One clock; reset is synchronous and active-low; all state updates on posedge clock.
- Reset values: pc=RESET_PC, state=FETCH, out_valid=0, out_pc=RESET_PC, out_inst=0, cache_fence_i=0.
- cache_addr = pc register (combinational, no latency). The icache holds cache_addr stable for the whole miss; pc changes only on capture or redirect.
- States: FETCH (waiting for hit, no output held), VALID (output held), FLUSH (invalidating).
- Priority in every state: reset > redirect_valid > capture/handshake.
- Redirect (redirect_valid=1):
  - Next cycle: pc = {redirect_pc[ADDR_WIDTH-1:2],2'b00} and out_valid=0; any held instruction is discarded.
  - If out_valid&&out_ready in the same cycle, that handshake still completes.
  - Next state is FLUSH if fence_i_req=1, else FETCH.
  - fence_i_req with redirect_valid=0 is ignored.
- FETCH:
  - cache_hit=1: out_inst<=cache_data, out_pc<=pc, out_valid<=1, pc<=pc+4, go to VALID.
  - cache_hit=0: hold.
- VALID:
  - out_ready=0: hold all outputs and pc; no lookup is consumed.
  - out_ready=1 && cache_hit=1: capture the next instruction the same cycle (out_pc<=pc, pc<=pc+4) and stay in VALID. This gives a throughput of 1 instruction/cycle on consecutive hits.
  - out_ready=1 && cache_hit=0: out_valid<=0, go to FETCH.
- FLUSH:
  - cache_fence_i=1 for exactly one cycle (Moore output of FLUSH); 0 in all other states.
  - cache_hit is ignored during FLUSH; nothing is captured.
  - Next state is FETCH at the redirected pc. A redirect arriving during FLUSH is taken; the flush pulse is still not extended.
- out_pc/out_inst are stable while out_valid=1 && out_ready=0.
- pc+4 wraps modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000).
- Hit-to-valid latency is 1 cycle. Miss latency is whatever the icache takes; no timeout.
- Reset asserted mid-miss or mid-hold: return to reset values the next edge. The icache shares the same reset, so no refill is orphaned.

Test Plan:
- Reset then hold: rst_n_sync=0 for 2 cycles, release; cache_hit=0 for 20 cycles -> cache_addr=32'h3000_0000 constant, out_valid=0 throughout.
- Sequential hits with out_ready=1: cache_hit=1 every cycle, data=addr^32'hA5A5A5A5 -> out_pc 0x30000000,0x30000004,0x30000008 on consecutive cycles, out_inst matching.
- Backpressure: out_valid=1, out_pc=0x30000004, out_ready=0 for 5 cycles -> out_pc/out_inst/cache_addr frozen. Raise out_ready with cache_hit=0 -> next cycle out_valid=0, state FETCH, cache_addr=0x30000008.
- Redirect during hold: out_valid=1, out_ready=0, redirect_valid=1, redirect_pc=0x30000103 -> next cycle out_valid=0, cache_addr=0x30000100. The discarded instruction is never accepted.
- fence.i: redirect_valid=1, fence_i_req=1, redirect_pc=0x30000040 -> cache_fence_i=1 for exactly one cycle; no capture that cycle even with cache_hit=1; first out_pc=0x30000040.
- Wrap: redirect to 0xFFFFFFFC, hit -> out_pc=0xFFFFFFFC, following cache_addr=0x00000000.
